// File: rtl/bcd_pkg.sv
// Shared types and BCD digit helpers for the operand sorter and its digit comparator.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  // Widest operand the invalid-digit scan handles; callers zero-extend to this width.
  localparam int MAX_DIGITS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic digit_is_valid(input logic [DIGIT_W-1:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

  function automatic logic any_digit_invalid(input logic [DIGIT_W*MAX_DIGITS-1:0] vec,
                                             input int digits);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (k < digits && !digit_is_valid(vec[k*DIGIT_W +: DIGIT_W])) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_cmp.sv
// Combinational magnitude compare of one BCD digit pair.
module bcd_digit_cmp
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               lt,
  output logic               eq,
  output logic               gt
);

  assign lt = a < b;
  assign eq = a == b;
  assign gt = a > b;

endmodule

// File: rtl/bcd_operand_sorter.sv
// Digit-serial MSD-first BCD magnitude comparator; returns L/E/G, max/min ordering and a swap flag.
module bcd_operand_sorter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] in_a,
  input  logic [DIGIT_W*DIGITS-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    lt,
  output logic                    eq,
  output logic                    gt,
  output logic [DIGIT_W*DIGITS-1:0] max_val,
  output logic [DIGIT_W*DIGITS-1:0] min_val,
  output logic                    swapped,
  output logic                    bcd_err
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // in_ready is high only in IDLE; out_valid is high only in DONE and all result
  // fields hold until the out transfer, after which the block returns to IDLE.

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;

  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic               d_lt;
  logic               d_eq;
  logic               d_gt;
  logic               in_bad;

  assign in_bad = any_digit_invalid((DIGIT_W*MAX_DIGITS)'(in_a), DIGITS) |
                  any_digit_invalid((DIGIT_W*MAX_DIGITS)'(in_b), DIGITS);

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_dig = a_q[k*DIGIT_W +: DIGIT_W];
        b_dig = b_q[k*DIGIT_W +: DIGIT_W];
      end
    end
  end

  bcd_digit_cmp u_digit_cmp (
    .a  (a_dig),
    .b  (b_dig),
    .lt (d_lt),
    .eq (d_eq),
    .gt (d_gt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= LAST_IDX;
      a_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      swapped   <= 1'b0;
      bcd_err   <= 1'b0;
      max_val   <= '0;
      min_val   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            idx_q    <= LAST_IDX;
            in_ready <= 1'b0;
            lt       <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            swapped  <= 1'b0;
            if (in_bad) begin
              // Malformed operands skip the digit walk and are passed through unordered.
              bcd_err   <= 1'b1;
              max_val   <= in_a;
              min_val   <= in_b;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end else begin
              bcd_err <= 1'b0;
              max_val <= '0;
              min_val <= '0;
              state_q <= CMP;
            end
          end
        end
        CMP: begin
          if (d_gt) begin
            gt        <= 1'b1;
            max_val   <= a_q;
            min_val   <= b_q;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else if (d_lt) begin
            lt        <= 1'b1;
            swapped   <= 1'b1;
            max_val   <= b_q;
            min_val   <= a_q;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else if (d_eq && idx_q == '0) begin
            eq        <= 1'b1;
            max_val   <= a_q;
            min_val   <= b_q;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
